// File: rtl/xgriscv_trace_buffer_if.sv
// ----------------------------------------------------------------------------
// xgriscv_trace_buffer_if
//
// Groups the trace-buffer sample input and its random-access read port.
//   in_valid/in_pc/in_instr : one retired pc/instr sample per cycle
//   rd_en/rd_addr           : read request, rd_addr 0 = oldest stored entry
//   rd_valid/rd_pc/rd_instr/rd_cycle : read response, one cycle after rd_en
//
// master : the side that supplies samples and issues reads (pipeline, bench)
// slave  : the trace buffer
// ----------------------------------------------------------------------------
interface xgriscv_trace_buffer_if #(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int AW    = 4,
    parameter int CNT_W = 32
);
    logic             in_valid;
    logic [XLEN-1:0]  in_pc;
    logic [ILEN-1:0]  in_instr;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic             rd_valid;
    logic [XLEN-1:0]  rd_pc;
    logic [ILEN-1:0]  rd_instr;
    logic [CNT_W-1:0] rd_cycle;

    modport master (
        output in_valid, in_pc, in_instr, rd_en, rd_addr,
        input  rd_valid, rd_pc, rd_instr, rd_cycle
    );

    modport slave (
        input  in_valid, in_pc, in_instr, rd_en, rd_addr,
        output rd_valid, rd_pc, rd_instr, rd_cycle
    );
endinterface

// File: rtl/xgriscv_trace_buffer.sv
// ----------------------------------------------------------------------------
// xgriscv_trace_buffer
//
// Circular execution-trace buffer of {pc, instr, cycle-stamp} entries with a
// PC-match trigger and a fixed post-trigger capture window.
//
// Ports:
//   clk, rstn   : clock (rising edge), asynchronous active-low reset
//   arm         : pulse; clears the buffer and starts capture (RUN)
//   trig_en     : enable the PC-match trigger
//   trig_pc     : PC value that fires the trigger
//   bus         : sample input and read port (xgriscv_trace_buffer_if.slave)
//   state       : 00 IDLE, 01 RUN, 10 POST, 11 DONE
//   triggered   : trigger has fired since the last arm
//   count       : stored entries, saturates at DEPTH
//   cycle_cnt   : free-running cycle counter, also the stamp source
// ----------------------------------------------------------------------------
module xgriscv_trace_buffer #(
    parameter int XLEN      = 32,
    parameter int ILEN      = 32,
    parameter int DEPTH     = 16,
    parameter int AW        = $clog2(DEPTH),
    parameter int CNT_W     = 32,
    parameter int POST_TRIG = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  arm,
    input  logic                  trig_en,
    input  logic [XLEN-1:0]       trig_pc,
    xgriscv_trace_buffer_if.slave bus,
    output logic [1:0]            state,
    output logic                  triggered,
    output logic [AW:0]           count,
    output logic [CNT_W-1:0]      cycle_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_POST = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [ILEN-1:0]  instr;
        logic [CNT_W-1:0] stamp;
    } entry_t;

    localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] POST_INI = AW'(POST_TRIG);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e           state_q,     state_d;
    logic [AW-1:0]    wr_ptr_q,    wr_ptr_d;
    logic [AW:0]      count_q,     count_d;
    logic [AW-1:0]    post_cnt_q,  post_cnt_d;
    logic             triggered_q, triggered_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic             rd_valid_q,  rd_valid_d;
    entry_t           rd_data_q,   rd_data_d;

    entry_t           mem_q [DEPTH];

    logic             wr_en;
    entry_t           wr_data;
    logic             capturing;
    logic             trig_hit;
    logic [AW-1:0]    rd_idx;
    logic             rd_hit;

    // Read index is relative to the oldest entry. When count == DEPTH its low
    // AW bits are zero, so the oldest entry is simply wr_ptr.
    assign rd_idx    = wr_ptr_q - count_q[AW-1:0] + bus.rd_addr;
    assign rd_hit    = ({1'b0, bus.rd_addr} < count_q);
    assign capturing = (state_q == ST_RUN) || (state_q == ST_POST);
    assign trig_hit  = trig_en && (bus.in_pc == trig_pc);
    assign wr_data   = '{pc: bus.in_pc, instr: bus.in_instr, stamp: cycle_cnt_q};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        post_cnt_d  = post_cnt_q;
        triggered_d = triggered_q;
        cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        wr_en       = 1'b0;

        if (arm) begin
            // arm wins over a same-cycle sample, which is dropped
            state_d     = ST_RUN;
            wr_ptr_d    = '0;
            count_d     = '0;
            post_cnt_d  = '0;
            triggered_d = 1'b0;
        end else if (capturing && bus.in_valid) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            count_d  = (count_q == FULL) ? count_q : count_q + (AW+1)'(1);

            if (state_q == ST_RUN) begin
                if (trig_hit) begin
                    triggered_d = 1'b1;
                    if (POST_TRIG == 0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_POST;
                        post_cnt_d = POST_INI;
                    end
                end
            end else begin
                // POST: matches are ignored, only the window counts down
                post_cnt_d = post_cnt_q - AW'(1);
                if (post_cnt_q == AW'(1)) begin
                    state_d = ST_DONE;
                end
            end
        end

        // Read uses pre-edge pointers and pre-write memory contents
        if (bus.rd_en) begin
            if (rd_hit) begin
                rd_valid_d = 1'b1;
                rd_data_d  = mem_q[rd_idx];
            end else begin
                rd_data_d  = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control and read-data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rstn) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            post_cnt_q  <= '0;
            triggered_q <= 1'b0;
            cycle_cnt_q <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            post_cnt_q  <= post_cnt_d;
            triggered_q <= triggered_d;
            cycle_cnt_q <= cycle_cnt_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Trace storage
    // ------------------------------------------------------------------
    // NOTE: the entry array has no reset. Entries are only visible through
    // count, which is reset, so stale contents can never be read out, and
    // leaving the array unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all registered)
    // ------------------------------------------------------------------
    assign state        = state_q;
    assign triggered    = triggered_q;
    assign count        = count_q;
    assign cycle_cnt    = cycle_cnt_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_pc    = rd_data_q.pc;
    assign bus.rd_instr = rd_data_q.instr;
    assign bus.rd_cycle = rd_data_q.stamp;

endmodule

// File: tb/tb_xgriscv_trace_buffer.sv
// ----------------------------------------------------------------------------
// tb_xgriscv_trace_buffer
//
// Directed bench for xgriscv_trace_buffer with DEPTH=4, POST_TRIG=2, CNT_W=32.
// Inputs change on the falling clock edge; outputs are checked on the falling
// edge after the rising edge that produced them.
// ----------------------------------------------------------------------------
module tb_xgriscv_trace_buffer;

    localparam int XLEN      = 32;
    localparam int ILEN      = 32;
    localparam int DEPTH     = 4;
    localparam int AW        = 2;
    localparam int CNT_W     = 32;
    localparam int POST_TRIG = 2;
    localparam logic [31:0] INSTR_XOR = 32'hDEAD_0013;

    logic             clk = 1'b1;
    logic             rstn;
    logic             arm;
    logic             trig_en;
    logic [XLEN-1:0]  trig_pc;
    logic [1:0]       state;
    logic             triggered;
    logic [AW:0]      count;
    logic [CNT_W-1:0] cycle_cnt;

    xgriscv_trace_buffer_if #(.XLEN(XLEN), .ILEN(ILEN), .AW(AW), .CNT_W(CNT_W)) bus ();

    xgriscv_trace_buffer #(
        .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .CNT_W(CNT_W), .POST_TRIG(POST_TRIG)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .arm      (arm),
        .trig_en  (trig_en),
        .trig_pc  (trig_pc),
        .bus      (bus),
        .state    (state),
        .triggered(triggered),
        .count    (count),
        .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    // Reference cycle counter: the stamp a sample should receive is this
    // value at the moment the sample is presented.
    logic [CNT_W-1:0] mcyc;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) mcyc <= '0;
        else       mcyc <= mcyc + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [CNT_W-1:0] last_stamp;
    logic [CNT_W-1:0] stamps [8];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        cyc();
        arm = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_pc    = pc;
        bus.in_instr = pc ^ INSTR_XOR;
        last_stamp   = mcyc;
        cyc();
        bus.in_valid = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        cyc();
        bus.rd_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn         = 1'b1;
        arm          = 1'b0;
        trig_en      = 1'b0;
        trig_pc      = '0;
        bus.in_valid = 1'b0;
        bus.in_pc    = '0;
        bus.in_instr = '0;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = '0;

        // ---- 1. asynchronous reset, then cycle counter start ----
        #5 rstn = 1'b0;
        #1;
        check("rst_state",     64'(state),        64'h0);
        check("rst_count",     64'(count),        64'h0);
        check("rst_cycle_cnt", 64'(cycle_cnt),    64'h0);
        check("rst_rd_valid",  64'(bus.rd_valid), 64'h0);
        check("rst_rd_pc",     64'(bus.rd_pc),    64'h0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        cyc(); cyc(); cyc();
        check("rst_cycle_cnt_3", 64'(cycle_cnt), 64'd3);

        // IDLE ignores samples
        push(32'h500);
        check("idle_count", 64'(count), 64'h0);
        check("idle_state", 64'(state), 64'h0);

        // ---- 2. wrap without trigger ----
        arm_pulse();
        check("arm_state", 64'(state), 64'h1);
        check("arm_count", 64'(count), 64'h0);
        for (int i = 0; i < 6; i++) begin
            push(32'(i * 4));
            stamps[i] = last_stamp;
        end
        check("wrap_count", 64'(count), 64'd4);
        check("wrap_state", 64'(state), 64'h1);
        for (int k = 0; k < 4; k++) begin
            rd(AW'(k));
            check($sformatf("wrap_valid%0d", k), 64'(bus.rd_valid), 64'h1);
            check($sformatf("wrap_pc%0d", k),    64'(bus.rd_pc),    64'(32'h08 + 32'(4 * k)));
            check($sformatf("wrap_instr%0d", k), 64'(bus.rd_instr), 64'((32'h08 + 32'(4 * k)) ^ INSTR_XOR));
            check($sformatf("wrap_cyc%0d", k),   64'(bus.rd_cycle), 64'(stamps[k + 2]));
        end

        // ---- 3. trigger plus post window ----
        trig_pc = 32'h0C;
        trig_en = 1'b1;
        arm_pulse();
        for (int i = 0; i < 8; i++) begin
            push(32'(i * 4));
            stamps[i] = last_stamp;
            if (i == 2) begin
                check("trig_before", 64'(triggered), 64'h0);
                check("trig_before_state", 64'(state), 64'h1);
            end
            if (i == 3) begin
                check("trig_fired", 64'(triggered), 64'h1);
                check("trig_post_state", 64'(state), 64'h2);
            end
            if (i == 4) check("post_mid_state", 64'(state), 64'h2);
            if (i == 5) check("post_done_state", 64'(state), 64'h3);
        end
        check("done_count", 64'(count), 64'd4);
        check("done_state", 64'(state), 64'h3);
        check("done_cycle_runs", 64'(cycle_cnt), 64'(mcyc));
        for (int k = 0; k < 4; k++) begin
            rd(AW'(k));
            check($sformatf("trig_valid%0d", k), 64'(bus.rd_valid), 64'h1);
            check($sformatf("trig_pc%0d", k),    64'(bus.rd_pc),    64'(32'h08 + 32'(4 * k)));
            check($sformatf("trig_cyc%0d", k),   64'(bus.rd_cycle), 64'(stamps[k + 2]));
        end

        // ---- 4. out-of-range reads, arm from DONE ----
        trig_en = 1'b0;
        arm_pulse();
        check("rearm_state",     64'(state),     64'h1);
        check("rearm_triggered", 64'(triggered), 64'h0);
        check("rearm_count",     64'(count),     64'h0);
        push(32'h100);
        push(32'h104);
        check("oor_count", 64'(count), 64'd2);
        rd(2'd3);
        check("oor3_valid", 64'(bus.rd_valid), 64'h0);
        check("oor3_pc",    64'(bus.rd_pc),    64'h0);
        check("oor3_cyc",   64'(bus.rd_cycle), 64'h0);
        rd(2'd1);
        check("rd1_valid", 64'(bus.rd_valid), 64'h1);
        check("rd1_pc",    64'(bus.rd_pc),    64'h104);
        cyc();
        check("noread_valid", 64'(bus.rd_valid), 64'h0);
        check("noread_hold",  64'(bus.rd_pc),    64'h104);
        rd(2'd2);
        check("oor2_valid", 64'(bus.rd_valid), 64'h0);
        rd(2'd0);
        check("rd0_pc", 64'(bus.rd_pc), 64'h100);

        // ---- 5. arm and in_valid in the same cycle ----
        arm          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_pc    = 32'h40;
        bus.in_instr = 32'h40 ^ INSTR_XOR;
        cyc();
        arm          = 1'b0;
        bus.in_valid = 1'b0;
        check("coll_count", 64'(count), 64'h0);
        check("coll_state", 64'(state), 64'h1);
        rd(2'd0);
        check("coll_rd_valid", 64'(bus.rd_valid), 64'h0);
        push(32'h44);
        check("coll_count1", 64'(count), 64'd1);
        // read and write in the same cycle: read sees pre-write state
        bus.rd_en    = 1'b1;
        bus.rd_addr  = 2'd0;
        bus.in_valid = 1'b1;
        bus.in_pc    = 32'h48;
        bus.in_instr = 32'h48 ^ INSTR_XOR;
        cyc();
        bus.rd_en    = 1'b0;
        bus.in_valid = 1'b0;
        check("rw_pc",    64'(bus.rd_pc), 64'h44);
        check("rw_count", 64'(count),     64'd2);
        rd(2'd1);
        check("rw_new_pc", 64'(bus.rd_pc), 64'h48);

        // ---- 6. reset in POST, then clean restart ----
        trig_pc = 32'h208;
        trig_en = 1'b1;
        arm_pulse();
        push(32'h200);
        push(32'h204);
        push(32'h208);
        check("mid_post_state", 64'(state), 64'h2);
        rstn = 1'b0;
        #1;
        check("midrst_state",     64'(state),        64'h0);
        check("midrst_triggered", 64'(triggered),    64'h0);
        check("midrst_count",     64'(count),        64'h0);
        check("midrst_rd_pc",     64'(bus.rd_pc),    64'h0);
        check("midrst_cycle",     64'(cycle_cnt),    64'h0);
        @(negedge clk);
        rstn    = 1'b1;
        trig_en = 1'b0;
        arm_pulse();
        check("restart_state", 64'(state), 64'h1);
        check("restart_count", 64'(count), 64'h0);
        push(32'h300);
        check("restart_count1", 64'(count), 64'd1);
        rd(2'd0);
        check("restart_valid", 64'(bus.rd_valid), 64'h1);
        check("restart_pc",    64'(bus.rd_pc),    64'h300);
        check("restart_cyc",   64'(bus.rd_cycle), 64'(last_stamp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
